// File: rtl/judge_requester_if.sv
// judge_requester_if: job intake, arbiter req/gnt handshake and bus beat signals of one requester
interface judge_requester_if #(parameter int ADDR_W = 8, parameter int LEN_W = 4);
  logic job_valid, job_ready;
  logic [ADDR_W-1:0] job_addr;
  logic [LEN_W-1:0] job_len;
  logic req, gnt, bus_en, bus_last, busy, starve, gnt_err;
  logic [ADDR_W-1:0] bus_addr;
  modport master (
    input job_valid, job_addr, job_len, gnt,
    output job_ready, req, bus_en, bus_addr, bus_last, busy, starve, gnt_err
  );
  modport slave (
    output job_valid, job_addr, job_len, gnt,
    input job_ready, req, bus_en, bus_addr, bus_last, busy, starve, gnt_err
  );
endinterface

// File: rtl/judge_requester.sv
// judge_requester: burst-job FIFO feeding a req/gnt handshake to the round-robin judge
module judge_requester #(
  parameter int ADDR_W = 8,
  parameter int LEN_W = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  judge_requester_if.master jr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_e;
  state_e state_q;
  logic [ADDR_W+LEN_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] beat_q;
  logic [CW-1:0] wait_q;
  logic req_q, starve_q, gnt_err_q;
  logic [ADDR_W-1:0] head_addr;
  logic [LEN_W-1:0] head_len;
  logic full, empty, push, pop;
  assign {head_addr, head_len} = mem_q[rd_q];
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign push = jr.job_valid & jr.job_ready;
  assign pop = jr.bus_en & jr.bus_last;
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign jr.job_ready = !full & !rst;
  assign jr.req = req_q;
  assign jr.bus_en = (state_q == XFER) & jr.gnt;
  assign jr.bus_last = jr.bus_en & (beat_q == head_len);
  assign jr.bus_addr = head_addr + ADDR_W'(beat_q);
  assign jr.busy = (state_q != IDLE) | !empty;
  assign jr.starve = starve_q;
  assign jr.gnt_err = gnt_err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {jr.job_addr, jr.job_len};
  // the head job stays in the FIFO until its last beat so a lost grant resumes at beat_q
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      beat_q <= '0;
      wait_q <= '0;
      starve_q <= 1'b0;
      gnt_err_q <= 1'b0;
    end else
      case (state_q)
        IDLE: begin
          if (jr.gnt) gnt_err_q <= 1'b1;
          if (!empty) begin
            state_q <= REQ;
            req_q <= 1'b1;
            wait_q <= '0;
          end
        end
        REQ:
          if (jr.gnt) state_q <= XFER;
          else if (wait_q == CW'(TIMEOUT - 1)) starve_q <= 1'b1;
          else wait_q <= wait_q + 1'b1;
        XFER:
          if (!jr.gnt) begin
            gnt_err_q <= 1'b1;
            req_q <= 1'b0;
            state_q <= RELEASE;
          end else if (beat_q == head_len) begin
            beat_q <= '0;
            req_q <= 1'b0;
            state_q <= RELEASE;
          end else beat_q <= beat_q + 1'b1;
        default:
          if (!jr.gnt) begin
            state_q <= empty ? IDLE : REQ;
            req_q <= !empty;
            wait_q <= '0;
          end
      endcase
endmodule

// File: tb/tb_judge_requester.sv
// tb_judge_requester: four requesters on a behavioural round-robin judge with per-port beat scoreboards
module tb_judge_requester;
  localparam int AW = 8, LW = 4, N = 4;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] jv, jrdy, req, gnt, jg, blk, frc, ben, blast, busy, starve, gerr;
  logic [AW-1:0] jaddr [N];
  logic [LW-1:0] jlen [N];
  logic [AW-1:0] baddr [N];
  int checks = 0, errors = 0;
  int beats [N];
  logic [AW:0] sb [N][$];
  int gseq [$];
  int own, last;
  logic [N-1:0] req_prev = '0;
  assign gnt = jg | frc;
  for (genvar g = 0; g < N; g++) begin : u
    judge_requester_if #(.ADDR_W(AW), .LEN_W(LW)) ifc ();
    assign ifc.job_valid = jv[g];
    assign ifc.job_addr = jaddr[g];
    assign ifc.job_len = jlen[g];
    assign ifc.gnt = gnt[g];
    assign jrdy[g] = ifc.job_ready;
    assign req[g] = ifc.req;
    assign ben[g] = ifc.bus_en;
    assign baddr[g] = ifc.bus_addr;
    assign blast[g] = ifc.bus_last;
    assign busy[g] = ifc.busy;
    assign starve[g] = ifc.starve;
    assign gerr[g] = ifc.gnt_err;
    judge_requester #(.ADDR_W(AW), .LEN_W(LW), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .jr(ifc)
    );
  end
  // registered round-robin judge: owner keeps gnt while its req stays high and it is not blocked
  always @(posedge clk or posedge rst)
    if (rst) begin
      jg <= '0;
      own <= 0;
      last <= N - 1;
    end else if (!(jg[own] && req[own] && !blk[own])) begin : pick
      logic [N-1:0] nx;
      int o;
      nx = '0;
      o = own;
      for (int k = 1; k <= N; k++)
        if (nx == '0 && req[(last + k) % N] && !blk[(last + k) % N]) begin
          o = (last + k) % N;
          nx[o] = 1'b1;
        end
      if (nx != '0) gseq.push_back(o);
      jg <= nx;
      own <= o;
      last <= (nx != '0) ? o : last;
    end
  always @(negedge clk) begin : mon
    logic [AW:0] e;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !req_prev[i]) begin
        checks++;
        if (gnt[i]) begin
          errors++;
          $display("FAIL req_rise_under_gnt port %0d: gnt=%0b at req rise, expected 0", i, gnt[i]);
        end
      end
      if (ben[i]) begin
        checks++;
        beats[i]++;
        if (sb[i].size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected port %0d: got last=%0b addr=%h, expected no beat", i, blast[i], baddr[i]);
        end else begin
          e = sb[i].pop_front();
          if ({blast[i], baddr[i]} !== e) begin
            errors++;
            $display("FAIL beat port %0d: got last=%0b addr=%h, expected last=%0b addr=%h",
                     i, blast[i], baddr[i], e[AW], e[AW-1:0]);
          end
        end
      end
    end
    req_prev = req;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    jv = '0;
    blk = '0;
    frc = '0;
    for (int i = 0; i < N; i++) begin
      sb[i].delete();
      beats[i] = 0;
    end
    gseq.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic push(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, output bit ok);
    int t = 0;
    jv[i] = 1'b1;
    jaddr[i] = a;
    jlen[i] = l;
    while (!jrdy[i] && t < 200) begin
      tick();
      t++;
    end
    ok = jrdy[i];
    if (ok) for (int b = 0; b <= int'(l); b++) sb[i].push_back({b == int'(l), a + AW'(b)});
    tick();
    jv[i] = 1'b0;
  endtask
  task automatic wait_idle(input logic [N-1:0] m, input int budget);
    int t = 0;
    while ((busy & m) != '0 && t < budget) begin
      tick();
      t++;
    end
  endtask
  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({req[i], ben[i], blast[i], busy[i], starve[i], gerr[i], jrdy[i]} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs port %0d: req,bus_en,bus_last,busy,starve,gnt_err,job_ready=%b, expected 0000000",
                 i, {req[i], ben[i], blast[i], busy[i], starve[i], gerr[i], jrdy[i]});
      end
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (jrdy !== 4'hF) begin
      errors++;
      $display("FAIL reset_release_ready: job_ready=%b, expected 1111", jrdy);
    end
  endtask
  task automatic test_gnt_idle();
    do_reset();
    frc[1] = 1'b1;
    tick();
    frc[1] = 1'b0;
    tick();
    checks++;
    if (gerr !== 4'b0010 || req !== 4'b0) begin
      errors++;
      $display("FAIL gnt_in_idle: gnt_err=%b req=%b, expected gnt_err=0010 req=0000", gerr, req);
    end
  endtask
  task automatic test_single();
    bit ok;
    do_reset();
    push(0, 8'h10, 4'd3, ok);
    checks++;
    if (!ok || req[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_push: accepted=%0b req=%0b, expected accepted=1 req=0", ok, req[0]);
    end
    tick();
    checks++;
    if (req[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_req_latency: req=%0b two cycles after push, expected 1", req[0]);
    end
    tick();
    checks++;
    if (gnt[0] !== 1'b1 || ben[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt_cycle: gnt=%0b bus_en=%0b, expected gnt=1 bus_en=0", gnt[0], ben[0]);
    end
    tick();
    checks++;
    if (ben[0] !== 1'b1 || baddr[0] !== 8'h10) begin
      errors++;
      $display("FAIL single_first_beat: bus_en=%0b addr=%h, expected bus_en=1 addr=10", ben[0], baddr[0]);
    end
    wait_idle(4'b0001, 50);
    checks++;
    if (busy[0] !== 1'b0 || req[0] !== 1'b0 || beats[0] != 4 || sb[0].size() != 0) begin
      errors++;
      $display("FAIL single_done: busy=%0b req=%0b beats=%0d pending=%0d, expected busy=0 req=0 beats=4 pending=0",
               busy[0], req[0], beats[0], sb[0].size());
    end
  endtask
  task automatic test_fifo_full();
    bit ok, all_ok;
    int t = 0;
    do_reset();
    blk[0] = 1'b1;
    all_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(0, AW'(8'h30 + 2 * k), 4'd1, ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || jrdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL fifo_fill: accepted_all=%0b job_ready=%0b, expected accepted_all=1 job_ready=0", all_ok, jrdy[0]);
    end
    jv[0] = 1'b1;
    jaddr[0] = 8'h50;
    jlen[0] = 4'd0;
    repeat (3) tick();
    checks++;
    if (jrdy[0] !== 1'b0 || beats[0] != 0) begin
      errors++;
      $display("FAIL fifo_hold: job_ready=%0b beats=%0d, expected job_ready=0 beats=0", jrdy[0], beats[0]);
    end
    blk[0] = 1'b0;
    while (!jrdy[0] && t < 100) begin
      tick();
      t++;
    end
    checks++;
    if (jrdy[0] !== 1'b1 || beats[0] != 2) begin
      errors++;
      $display("FAIL fifo_ready_after_pop: job_ready=%0b beats=%0d, expected job_ready=1 beats=2", jrdy[0], beats[0]);
    end
    push(0, 8'h50, 4'd0, ok);
    wait_idle(4'b0001, 200);
    checks++;
    if (!ok || busy[0] !== 1'b0 || beats[0] != 9 || sb[0].size() != 0) begin
      errors++;
      $display("FAIL fifo_done: accepted=%0b busy=%0b beats=%0d pending=%0d, expected 1 0 9 0",
               ok, busy[0], beats[0], sb[0].size());
    end
  endtask
  task automatic test_starve();
    bit ok;
    int t = 0;
    do_reset();
    blk[0] = 1'b1;
    push(0, 8'h60, 4'd1, ok);
    while (!req[0] && t < 10) begin
      tick();
      t++;
    end
    repeat (63) tick();
    checks++;
    if (!ok || req[0] !== 1'b1 || starve[0] !== 1'b0) begin
      errors++;
      $display("FAIL starve_early: accepted=%0b req=%0b starve=%0b after 63 waits, expected 1 1 0", ok, req[0], starve[0]);
    end
    tick();
    checks++;
    if (starve[0] !== 1'b1) begin
      errors++;
      $display("FAIL starve_raise: starve=%0b after 64 waits, expected 1", starve[0]);
    end
    repeat (5) tick();
    checks++;
    if (starve[0] !== 1'b1 || req[0] !== 1'b1 || ben[0] !== 1'b0) begin
      errors++;
      $display("FAIL starve_wait: starve=%0b req=%0b bus_en=%0b, expected 1 1 0", starve[0], req[0], ben[0]);
    end
    blk[0] = 1'b0;
    wait_idle(4'b0001, 50);
    checks++;
    if (starve[0] !== 1'b1 || busy[0] !== 1'b0 || beats[0] != 2 || sb[0].size() != 0) begin
      errors++;
      $display("FAIL starve_late_gnt: starve=%0b busy=%0b beats=%0d pending=%0d, expected 1 0 2 0",
               starve[0], busy[0], beats[0], sb[0].size());
    end
  endtask
  task automatic test_gnt_loss();
    bit ok;
    int t = 0;
    do_reset();
    push(0, 8'h20, 4'd3, ok);
    while (!ben[0] && t < 10) begin
      tick();
      t++;
    end
    tick();
    blk[0] = 1'b1;
    tick();
    checks++;
    if (!ok || gnt[0] !== 1'b0 || ben[0] !== 1'b0 || beats[0] != 2) begin
      errors++;
      $display("FAIL loss_drop: accepted=%0b gnt=%0b bus_en=%0b beats=%0d, expected 1 0 0 2", ok, gnt[0], ben[0], beats[0]);
    end
    tick();
    checks++;
    if (req[0] !== 1'b0 || gerr[0] !== 1'b1) begin
      errors++;
      $display("FAIL loss_release: req=%0b gnt_err=%0b, expected req=0 gnt_err=1", req[0], gerr[0]);
    end
    blk[0] = 1'b0;
    wait_idle(4'b0001, 50);
    checks++;
    if (busy[0] !== 1'b0 || beats[0] != 4 || sb[0].size() != 0 || gerr[0] !== 1'b1) begin
      errors++;
      $display("FAIL loss_resume: busy=%0b beats=%0d pending=%0d gnt_err=%0b, expected 0 4 0 1",
               busy[0], beats[0], sb[0].size(), gerr[0]);
    end
  endtask
  task automatic test_wrap();
    bit ok;
    do_reset();
    push(0, 8'hFE, 4'd2, ok);
    wait_idle(4'b0001, 50);
    checks++;
    if (!ok || busy[0] !== 1'b0 || beats[0] != 3 || sb[0].size() != 0) begin
      errors++;
      $display("FAIL wrap: accepted=%0b busy=%0b beats=%0d pending=%0d, expected 1 0 3 0", ok, busy[0], beats[0], sb[0].size());
    end
  endtask
  task automatic test_judge();
    int t = 0;
    bit bad;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        jv[i] = 1'b1;
        jaddr[i] = AW'(8'h40 * i + 8'h20 * k);
        jlen[i] = LW'(i + k);
        for (int b = 0; b <= i + k; b++) sb[i].push_back({b == i + k, jaddr[i] + AW'(b)});
      end
      checks++;
      if (jrdy !== 4'hF) begin
        errors++;
        $display("FAIL judge_push%0d: job_ready=%b, expected 1111", k, jrdy);
      end
      tick();
      jv = '0;
    end
    wait_idle(4'hF, 400);
    bad = gseq.size() != 8;
    for (int j = 0; j < gseq.size() && j < 8; j++) bad |= gseq[j] != j % N;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL judge_rotation: %0d grants starting %0d,%0d,%0d,%0d, expected 8 grants 0,1,2,3,0,1,2,3",
               gseq.size(), gseq.size() > 0 ? gseq[0] : -1, gseq.size() > 1 ? gseq[1] : -1,
               gseq.size() > 2 ? gseq[2] : -1, gseq.size() > 3 ? gseq[3] : -1);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (busy[i] !== 1'b0 || beats[i] != 2 * i + 3 || sb[i].size() != 0) begin
        errors++;
        $display("FAIL judge_done port %0d: busy=%0b beats=%0d pending=%0d, expected busy=0 beats=%0d pending=0",
                 i, busy[i], beats[i], sb[i].size(), 2 * i + 3);
      end
    end
    for (int i = 0; i < N; i++) begin
      jv[i] = 1'b1;
      jaddr[i] = AW'(8'h10 * i);
      jlen[i] = 4'd7;
      for (int b = 0; b <= 7; b++) sb[i].push_back({b == 7, jaddr[i] + AW'(b)});
    end
    tick();
    jv = '0;
    while (ben == '0 && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (ben == '0) begin
      errors++;
      $display("FAIL midburst_start: bus_en=%b, expected a beat within 20 cycles", ben);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) sb[i].delete();
    #1;
    checks++;
    if (ben !== 4'b0 || req !== 4'b0 || busy !== 4'b0 || jrdy !== 4'b0) begin
      errors++;
      $display("FAIL midburst_reset: bus_en=%b req=%b busy=%b job_ready=%b, expected all 0000", ben, req, busy, jrdy);
    end
    tick();
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 4'b0 || req !== 4'b0 || jrdy !== 4'hF) begin
      errors++;
      $display("FAIL midburst_flushed: busy=%b req=%b job_ready=%b, expected 0000 0000 1111", busy, req, jrdy);
    end
  endtask
  initial begin
    jv = '0;
    blk = '0;
    frc = '0;
    for (int i = 0; i < N; i++) begin
      jaddr[i] = '0;
      jlen[i] = '0;
      beats[i] = 0;
    end
    test_reset();
    test_gnt_idle();
    test_single();
    test_fifo_full();
    test_starve();
    test_gnt_loss();
    test_wrap();
    test_judge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1000000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
